uart_rx_fifo_wr: RTL and testbench

Serial receive front-end that feeds the 8-bit, 16-entry FIFO from its write side. It recovers 8N1 asynchronous serial frames from a single `rx` line, oversampling with a programmable clocks-per-bit divider. Each good byte is pushed into the FIFO with a one-cycle `wr` pulse on `din`. Framing errors and FIFO overruns are reported as sticky flags, and the offending byte is dropped.

---
 rtl/uart_rx_fifo_wr.sv | 92 +++++++++
 tb/tb_uart_rx_fifo_wr.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_wr.sv
// uart_rx_fifo_wr: 8N1 serial receiver that pushes good bytes into a FIFO write port
// and reports framing errors and overruns as sticky flags.
module uart_rx_fifo_wr #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       full,
    input  logic       clr_err,
    output logic       wr,
    output logic [7:0] din,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;

    state_t          state_q, state_d;
    logic [1:0]      sync_q, sync_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            wr_q, wr_d;
    logic [7:0]      din_q, din_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic            rx_s, sample, stop_ok, stop_bad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sync_q      <= 2'b11;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            wr_q        <= 1'b0;
            din_q       <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            wr_q        <= wr_d;
            din_q       <= din_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!rx_s) state_d = START;
            START:   if (sample) state_d = rx_s ? IDLE : DATA;
            DATA:    if (sample && bit_q == 3'd7) state_d = STOP;
            STOP:    if (sample) state_d = rx_s ? IDLE : WAIT_HI;
            WAIT_HI: if (rx_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Start bit is checked mid-bit; every later sample lands one full bit further on.
    always_comb begin
        rx_s        = sync_q[1];
        sync_d      = {sync_q[0], rx};
        sample      = (state_q == START) ? (cnt_q == HALF_LAST)
                                         : (state_q == DATA || state_q == STOP) && cnt_q == BIT_LAST;
        stop_ok     = state_q == STOP && sample && rx_s;
        stop_bad    = state_q == STOP && sample && !rx_s;
        cnt_d       = (state_q == IDLE || sample) ? '0 : cnt_q + 1'b1;
        bit_d       = (state_q == START) ? 3'd0 : (state_q == DATA && sample) ? bit_q + 3'd1 : bit_q;
        shift_d     = (state_q == DATA && sample) ? {rx_s, shift_q[7:1]} : shift_q;
        wr_d        = stop_ok && !full;
        din_d       = wr_d ? shift_q : din_q;
        overrun_d   = (stop_ok && full) || (overrun_q && !clr_err);
        frame_err_d = stop_bad || (frame_err_q && !clr_err);
    end

    assign wr        = wr_q;
    assign din       = din_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_fifo_wr.sv
// tb_uart_rx_fifo_wr: scenario tasks drive serial frames and compare the FIFO writes
// and flags against a frame-level model of what the receiver should produce.
module tb_uart_rx_fifo_wr;
    localparam int CPB = 16;
    localparam int H   = CPB / 2;
    // rx fall to wr visible: 3 edges of synchronizer/IDLE, then the stop-sample offset
    localparam int LAT = 3 + H + 9 * CPB;

    logic       clk = 1'b0, rst = 1'b0, rx = 1'b1, full = 1'b0, clr_err = 1'b0;
    logic       wr, frame_err, overrun, busy;
    logic [7:0] din;
    int         cyc = 0, passed = 0, checks = 0;
    logic [7:0] got_b[$], exp_b[$];
    int         got_t[$], exp_t[$];
    logic [7:0] last_din = 8'h00;
    logic       exp_ovr = 1'b0, exp_fe = 1'b0;

    uart_rx_fifo_wr #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .rx(rx), .full(full), .clr_err(clr_err),
        .wr(wr), .din(din), .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (wr) begin got_b.push_back(din); got_t.push_back(cyc); end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        got_b.delete(); got_t.delete(); exp_b.delete(); exp_t.delete();
        exp_ovr = 1'b0; exp_fe = 1'b0;
    endtask

    // Frame-level model: what one frame must produce, given its stop bit and full at stop.
    task automatic model_frame(input logic [7:0] b, input bit stop, input bit fs, input int tf);
        if (!stop) exp_fe = 1'b1;
        else if (fs) exp_ovr = 1'b1;
        else begin exp_b.push_back(b); exp_t.push_back(tf + LAT); last_din = b; end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop, input bit fs, output int tf);
        tf = cyc;
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin rx = b[i]; tick(CPB); end
        rx = stop; full = fs;
        tick(CPB);
        full = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1; tick(1); clr_err = 1'b0; tick(1);
    endtask

    task automatic test_reset();
        tick(3);
        checks++; if ({wr, din, frame_err, overrun, busy} !== 12'h0) $display("FAIL reset_hold: got %b want 0", {wr, din, frame_err, overrun, busy}); else passed++;
        rst = 1'b1;
        tick(5);
        checks++; if ({wr, din, frame_err, overrun, busy} !== 12'h0) $display("FAIL reset_release: got %b want 0", {wr, din, frame_err, overrun, busy}); else passed++;
    endtask

    task automatic test_single();
        int tf;
        clear_logs();
        send_frame(8'hA5, 1, 0, tf); model_frame(8'hA5, 1, 0, tf);
        tick(20);
        checks++; if (got_b.size() !== 1) $display("FAIL single_count: got %0d want 1", got_b.size()); else passed++;
        checks++; if (got_t.size() > 0 && got_t[0] !== exp_t[0]) $display("FAIL single_time: got %0d want %0d", got_t[0], exp_t[0]); else passed++;
        checks++; if (got_b.size() > 0 && got_b[0] !== 8'hA5) $display("FAIL single_byte: got %h want a5", got_b[0]); else passed++;
        checks++; if ({frame_err, overrun, busy} !== 3'b000) $display("FAIL single_flags: got %b want 000", {frame_err, overrun, busy}); else passed++;
        checks++; if (din !== 8'hA5) $display("FAIL single_din_hold: got %h want a5", din); else passed++;
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        clear_logs();
        send_frame(8'h00, 1, 0, t1); model_frame(8'h00, 1, 0, t1);
        send_frame(8'hFF, 1, 0, t2); model_frame(8'hFF, 1, 0, t2);
        tick(20);
        checks++; if (got_b.size() !== 2) $display("FAIL b2b_count: got %0d want 2", got_b.size()); else passed++;
        if (got_b.size() == 2) begin
            checks++; if (got_t[1] - got_t[0] !== 160) $display("FAIL b2b_gap: got %0d want 160", got_t[1] - got_t[0]); else passed++;
            checks++; if ({got_b[0], got_b[1]} !== {exp_b[0], exp_b[1]}) $display("FAIL b2b_bytes: got %h want %h", {got_b[0], got_b[1]}, {exp_b[0], exp_b[1]}); else passed++;
            checks++; if (got_t[0] !== exp_t[0]) $display("FAIL b2b_time: got %0d want %0d", got_t[0], exp_t[0]); else passed++;
        end
    endtask

    task automatic test_glitch();
        int n = 0;
        clear_logs();
        for (int i = 0; i < 44; i++) begin
            rx = (i < 4) ? 1'b0 : 1'b1;
            tick(1);
            n += int'(busy);
        end
        checks++; if (n !== H) $display("FAIL glitch_busy_cycles: got %0d want %0d", n, H); else passed++;
        checks++; if (got_b.size() !== 0) $display("FAIL glitch_wr: got %0d writes want 0", got_b.size()); else passed++;
        checks++; if ({frame_err, overrun, busy} !== 3'b000) $display("FAIL glitch_flags: got %b want 000", {frame_err, overrun, busy}); else passed++;
    endtask

    task automatic test_overrun();
        int tf;
        clear_logs();
        // clr_err lands on the stop-sample edge itself: the set must win
        fork
            begin send_frame(8'h3C, 1, 1, tf); end
            begin tick(LAT - 1); clr_err = 1'b1; tick(1); clr_err = 1'b0; end
        join
        model_frame(8'h3C, 1, 1, tf);
        tick(10);
        checks++; if (got_b.size() !== 0) $display("FAIL ovr_wr: got %0d writes want 0", got_b.size()); else passed++;
        checks++; if (overrun !== exp_ovr) $display("FAIL ovr_set: got %b want %b", overrun, exp_ovr); else passed++;
        checks++; if (frame_err !== exp_fe) $display("FAIL ovr_fe: got %b want %b", frame_err, exp_fe); else passed++;
        checks++; if (din !== last_din) $display("FAIL ovr_din_hold: got %h want %h", din, last_din); else passed++;
        pulse_clr();
        checks++; if (overrun !== 1'b0) $display("FAIL ovr_clear: got %b want 0", overrun); else passed++;
    endtask

    task automatic test_break();
        int tf, n = 0;
        clear_logs();
        send_frame(8'hC3, 0, 0, tf); model_frame(8'hC3, 0, 0, tf);
        repeat (500) begin tick(1); n += int'(!busy); end
        checks++; if (n !== 0) $display("FAIL break_retrigger: busy low %0d cycles want 0", n); else passed++;
        checks++; if ({frame_err, overrun} !== {exp_fe, exp_ovr}) $display("FAIL break_flags: got %b want %b", {frame_err, overrun}, {exp_fe, exp_ovr}); else passed++;
        checks++; if (got_b.size() !== 0) $display("FAIL break_wr: got %0d writes want 0", got_b.size()); else passed++;
        rx = 1'b1;
        tick(10);
        checks++; if (busy !== 1'b0) $display("FAIL break_exit: busy %b want 0", busy); else passed++;
        pulse_clr();
        checks++; if (frame_err !== 1'b0) $display("FAIL break_clear: got %b want 0", frame_err); else passed++;
        clear_logs();
        send_frame(8'h5A, 1, 0, tf); model_frame(8'h5A, 1, 0, tf);
        tick(20);
        checks++; if (got_b.size() !== 1 || got_b[0] !== 8'h5A || got_t[0] !== exp_t[0]) $display("FAIL break_next: got %0d writes first %h want 1 write 5a", got_b.size(), got_b.size() > 0 ? got_b[0] : 8'h00); else passed++;
    endtask

    task automatic test_reset_mid();
        int tf;
        clear_logs();
        fork
            begin send_frame(8'h81, 1, 0, tf); end
            begin
                tick(3 + H + 5 * CPB);
                #3;
                checks++; if (busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b want 1", busy); else passed++;
                rst = 1'b0;
                #1;
                checks++; if ({wr, din, frame_err, overrun, busy} !== 12'h0) $display("FAIL rstmid_outputs: got %b want 0", {wr, din, frame_err, overrun, busy}); else passed++;
            end
        join
        tick(2);
        rst = 1'b1;
        last_din = 8'h00;
        tick(10);
        checks++; if (got_b.size() !== 0) $display("FAIL rstmid_wr: got %0d writes want 0", got_b.size()); else passed++;
        send_frame(8'h81, 1, 0, tf); model_frame(8'h81, 1, 0, tf);
        tick(20);
        checks++; if (got_b.size() !== 1 || got_b[0] !== 8'h81 || got_t[0] !== exp_t[0]) $display("FAIL rstmid_next: got %0d writes first %h want 1 write 81", got_b.size(), got_b.size() > 0 ? got_b[0] : 8'h00); else passed++;
    endtask

    task automatic test_random();
        int tf;
        clear_logs();
        for (int i = 0; i < 10; i++) begin
            logic [7:0] b = 8'($urandom);
            bit fs = ($urandom_range(0, 3) == 0);
            tick($urandom_range(0, 20));
            send_frame(b, 1, fs, tf);
            model_frame(b, 1, fs, tf);
        end
        tick(20);
        checks++; if (got_b.size() !== exp_b.size()) $display("FAIL rand_count: got %0d want %0d", got_b.size(), exp_b.size()); else passed++;
        for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
            checks++; if (got_b[i] !== exp_b[i] || got_t[i] !== exp_t[i]) $display("FAIL rand_write%0d: got %h@%0d want %h@%0d", i, got_b[i], got_t[i], exp_b[i], exp_t[i]); else passed++;
        end
        checks++; if (overrun !== exp_ovr) $display("FAIL rand_overrun: got %b want %b", overrun, exp_ovr); else passed++;
        checks++; if (din !== last_din) $display("FAIL rand_din: got %h want %h", din, last_din); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_overrun();
        test_break();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
